// File: rtl/dispatch_sched_pkg.sv
// Shared types and the round-robin pick helper for dispatch_scheduler.
package dispatch_sched_pkg;

   localparam int DEST_W = 6;
   localparam int NT_MAX = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARB  = 2'd1,
      S_SEND = 2'd2
   } state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   // First set bit of elig scanning ptr, ptr+1, ... modulo nt.
   function automatic pick_t rr_pick(
      input logic [NT_MAX-1:0] elig,
      input logic [2:0]        ptr,
      input int                nt
   );
      pick_t r;
      int    j;
      r = '0;
      for (int k = 0; k < NT_MAX; k++) begin
         j = (int'(ptr) + k) % nt;
         if (k < nt && !r.found && elig[j[2:0]]) begin
            r.found = 1'b1;
            r.idx   = j[2:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tile_credit_ctr.sv
// Outstanding-packet counter for one destination tile.
module tile_credit_ctr #(
   parameter int MAX_OUT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic avail,
   output logic underflow
);

   logic [3:0] cnt;

   // A grant and a done on the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && !dec) begin
         cnt <= cnt + 4'd1;
      end else if (dec && !inc && cnt != 4'd0) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign avail     = cnt < 4'(MAX_OUT);
   assign underflow = dec && (cnt == 4'd0);

endmodule

// File: rtl/dispatch_scheduler.sv
// Credit-gated round-robin packet dispatcher with header dest rewrite.
// DISPATCH_SCHED_STATS_EN adds per-tile completed-packet counters.
module dispatch_scheduler
   import dispatch_sched_pkg::*;
#(
   parameter int NT        = 4,
   parameter int BW        = 32,
   parameter int BWB       = 4,
   parameter int MAX_OUT   = 2,
   parameter int DEST_LSB  = 0,
   parameter int TILE_BASE = 1
) (
   input  logic             clk_line,
   input  logic             clk_line_rst_high,
   input  logic             s_TVALID,
   input  logic [BW-1:0]    s_TDATA,
   input  logic [BWB-1:0]   s_TKEEP,
   input  logic             s_TLAST,
   output logic             s_TREADY,
   output logic             m_TVALID,
   output logic [BW-1:0]    m_TDATA,
   output logic [BWB-1:0]   m_TKEEP,
   output logic             m_TLAST,
   input  logic             m_TREADY,
   input  logic [NT-1:0]    tile_done,
   input  logic [NT-1:0]    cfg_tile_mask,
   output logic [NT-1:0]    grant_sel,
   output logic             busy,
   output logic             err_underflow
`ifdef DISPATCH_SCHED_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [NT*16-1:0] pkt_count
`endif
);

   localparam int SW = $clog2(NT);

   state_t              state;
   logic [SW-1:0]       sel;
   logic [SW-1:0]       rr_ptr;
   logic                first;
   logic [NT-1:0]       avail;
   logic [NT-1:0]       elig;
   logic [NT-1:0]       inc;
   logic [NT-1:0]       udf;
   logic                in_send;
   logic                hs;
   logic                done_pkt;
   pick_t               pick;
   logic [DEST_W-1:0]   tile_id;

   assign elig     = cfg_tile_mask & avail;
   assign pick     = rr_pick(NT_MAX'(elig), 3'(rr_ptr), NT);
   assign in_send  = (state == S_SEND);
   assign hs       = in_send && s_TVALID && m_TREADY;
   assign done_pkt = hs && s_TLAST;
   assign inc      = (state == S_ARB && pick.found) ?
                     (NT'(1) << pick.idx) : '0;

   for (genvar i = 0; i < NT; i++) begin : g_tile
      tile_credit_ctr #(
         .MAX_OUT(MAX_OUT)
      ) u_ctr (
         .clk      (clk_line),
         .rst      (clk_line_rst_high),
         .inc      (inc[i]),
         .dec      (tile_done[i]),
         .avail    (avail[i]),
         .underflow(udf[i])
      );
   end

   always_ff @(posedge clk_line) begin
      if (clk_line_rst_high) begin
         state         <= S_IDLE;
         sel           <= '0;
         rr_ptr        <= '0;
         first         <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (|udf) err_underflow <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (s_TVALID && |elig) state <= S_ARB;
            end
            S_ARB: begin
               if (pick.found) begin
                  sel   <= SW'(pick.idx);
                  first <= 1'b1;
                  state <= S_SEND;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SEND: begin
               if (hs) first <= 1'b0;
               if (done_pkt) begin
                  state  <= S_IDLE;
                  rr_ptr <= (sel == SW'(NT - 1)) ? '0 : sel + SW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign tile_id = DEST_W'(TILE_BASE) + DEST_W'(sel);

   always_comb begin
      m_TDATA = s_TDATA;
      if (first) m_TDATA[DEST_LSB +: DEST_W] = tile_id;
   end

   assign s_TREADY  = in_send && m_TREADY;
   assign m_TVALID  = in_send && s_TVALID;
   assign m_TKEEP   = s_TKEEP;
   assign m_TLAST   = s_TLAST;
   assign grant_sel = in_send ? (NT'(1) << sel) : '0;
   assign busy      = (state != S_IDLE);

`ifdef DISPATCH_SCHED_STATS_EN
   logic [15:0] pc [NT];

   for (genvar i = 0; i < NT; i++) begin : g_stat
      always_ff @(posedge clk_line) begin
         if (clk_line_rst_high || stats_clr) begin
            pc[i] <= '0;
         end else if (done_pkt && sel == SW'(i)) begin
            pc[i] <= pc[i] + 16'd1;
         end
      end
      assign pkt_count[i*16 +: 16] = pc[i];
   end
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler with an output-beat scoreboard.
module tb_dispatch_scheduler;

   localparam int NT        = 4;
   localparam int TILE_BASE = 1;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
      logic [3:0]  g;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_TVALID;
   logic [31:0]   s_TDATA;
   logic [3:0]    s_TKEEP;
   logic          s_TLAST;
   logic          s_TREADY;
   logic          m_TVALID;
   logic [31:0]   m_TDATA;
   logic [3:0]    m_TKEEP;
   logic          m_TLAST;
   logic          m_TREADY = 1'b1;
   logic [NT-1:0] tile_done;
   logic [NT-1:0] cfg_tile_mask;
   logic [NT-1:0] grant_sel;
   logic          busy;
   logic          err_underflow;

   exp_t sbq[$];
   bit   rdy_q[$];
   int   total = 0;
   int   bad = 0;
   int   stalls = 0;

   dispatch_scheduler #(
      .NT(NT), .BW(32), .BWB(4), .MAX_OUT(2),
      .DEST_LSB(0), .TILE_BASE(TILE_BASE)
   ) dut (
      .clk_line         (clk),
      .clk_line_rst_high(rst),
      .s_TVALID         (s_TVALID),
      .s_TDATA          (s_TDATA),
      .s_TKEEP          (s_TKEEP),
      .s_TLAST          (s_TLAST),
      .s_TREADY         (s_TREADY),
      .m_TVALID         (m_TVALID),
      .m_TDATA          (m_TDATA),
      .m_TKEEP          (m_TKEEP),
      .m_TLAST          (m_TLAST),
      .m_TREADY         (m_TREADY),
      .tile_done        (tile_done),
      .cfg_tile_mask    (cfg_tile_mask),
      .grant_sel        (grant_sel),
      .busy             (busy),
      .err_underflow    (err_underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (rdy_q.size() > 0) m_TREADY = rdy_q.pop_front();
      else m_TREADY = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t mk_exp(input logic [31:0] d, input int tile,
                                   input bit first, input bit last);
      exp_t e;
      e.d = d;
      if (first) e.d[5:0] = 6'(TILE_BASE + tile);
      e.k = last ? 4'h3 : 4'hF;
      e.l = last;
      e.g = 4'(1 << tile);
      return e;
   endfunction

   task automatic monitor();
      logic        hold_v = 1'b0;
      logic [31:0] hd = '0;
      logic        hl = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst && m_TVALID) begin
            if (hold_v) begin
               chk("stall_data", m_TDATA, hd);
               chk("stall_last", 32'(m_TLAST), 32'(hl));
            end
            if (m_TREADY) begin
               hold_v = 1'b0;
               if (sbq.size() == 0) begin
                  chk("unexpected_beat", 32'(m_TVALID), 32'd0);
               end else begin
                  e = sbq.pop_front();
                  chk("data", m_TDATA, e.d);
                  chk("keep", 32'(m_TKEEP), 32'(e.k));
                  chk("last", 32'(m_TLAST), 32'(e.l));
                  chk("grant", 32'(grant_sel), 32'(e.g));
               end
            end else begin
               hold_v = 1'b1;
               hd     = m_TDATA;
               hl     = m_TLAST;
               stalls++;
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   endtask

   task automatic drive_beat(input logic [31:0] d, input bit last);
      bit ok = 1'b0;
      s_TVALID = 1'b1;
      s_TDATA  = d;
      s_TKEEP  = last ? 4'h3 : 4'hF;
      s_TLAST  = last;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = s_TREADY;
      end
      chk("beat_accepted", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int nb, input int tile,
                           input logic [31:0] hdr);
      logic [31:0] d[$];
      for (int b = 0; b < nb; b++) begin
         d.push_back((b == 0) ? hdr : 32'($urandom));
         sbq.push_back(mk_exp(d[b], tile, b == 0, b == nb - 1));
      end
      for (int b = 0; b < nb; b++) drive_beat(d[b], b == nb - 1);
      s_TVALID = 1'b0;
      s_TLAST  = 1'b0;
   endtask

   task automatic pulse_done(input logic [NT-1:0] v);
      tile_done = v;
      @(posedge clk);
      #1;
      tile_done = '0;
   endtask

   initial begin
      logic [31:0] hdr;
      logic [31:0] d1;
      s_TVALID      = 1'b0;
      s_TDATA       = '0;
      s_TKEEP       = 4'hF;
      s_TLAST       = 1'b0;
      tile_done     = '0;
      cfg_tile_mask = 4'hF;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", 32'(s_TREADY), 32'd0);
      chk("rst_m_tvalid", 32'(m_TVALID), 32'd0);
      chk("rst_grant", 32'(grant_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_underflow), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int t = 0; t < 4; t++) send_pkt(3, t, 32'($urandom));
      for (int t = 0; t < 4; t++) send_pkt(3, t, 32'($urandom));

      hdr      = 32'hCAFE_F0FF;
      s_TVALID = 1'b1;
      s_TDATA  = hdr;
      s_TKEEP  = 4'hF;
      s_TLAST  = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("full_s_tready", 32'(s_TREADY), 32'd0);
      end
      chk("full_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      pulse_done(4'b0100);
      send_pkt(3, 2, hdr);

      pulse_done(4'hF);
      pulse_done(4'hF);
      @(negedge clk);
      chk("no_spurious_err", 32'(err_underflow), 32'd0);
      @(posedge clk);
      #1;

      cfg_tile_mask = 4'b1010;
      send_pkt(2, 3, 32'($urandom));
      send_pkt(2, 1, 32'($urandom));
      send_pkt(1, 3, 32'($urandom));
      send_pkt(1, 1, 32'($urandom));
      cfg_tile_mask = 4'b0000;
      s_TVALID      = 1'b1;
      s_TDATA       = 32'h1357_9BDF;
      repeat (3) begin
         @(negedge clk);
         chk("mask0_busy", 32'(busy), 32'd0);
         chk("mask0_m_tvalid", 32'(m_TVALID), 32'd0);
      end
      @(posedge clk);
      #1;
      s_TVALID = 1'b0;
      pulse_done(4'b1010);
      pulse_done(4'b1010);
      cfg_tile_mask = 4'hF;

      rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      send_pkt(4, 2, 32'h0BAD_BEEF);
      chk("stalls_seen", 32'(stalls > 0), 32'd1);
      send_pkt(1, 3, 32'hFFFF_FFC0);

      pulse_done(4'b0001);
      @(negedge clk);
      chk("underflow_set", 32'(err_underflow), 32'd1);
      chk("cnt0_floor", 32'(dut.g_tile[0].u_ctr.cnt), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("underflow_held", 32'(err_underflow), 32'd1);
      @(posedge clk);
      #1;

      send_pkt(1, 0, 32'($urandom));
      send_pkt(1, 1, 32'($urandom));
      cfg_tile_mask = 4'b0010;
      hdr      = 32'h7777_0000;
      s_TVALID = 1'b1;
      s_TDATA  = hdr;
      s_TKEEP  = 4'hF;
      s_TLAST  = 1'b0;
      @(posedge clk);
      #1;
      chk("arb_busy", 32'(busy), 32'd1);
      chk("arb_grant", 32'(grant_sel), 32'd0);
      tile_done = 4'b0010;
      @(posedge clk);
      #1;
      tile_done = '0;
      chk("cnt1_net", 32'(dut.g_tile[1].u_ctr.cnt), 32'd1);
      send_pkt(2, 1, hdr);
      cfg_tile_mask = 4'hF;

      hdr = 32'hA5A5_A5A5;
      d1  = 32'h5A5A_5A5A;
      sbq.push_back(mk_exp(hdr, 2, 1'b1, 1'b0));
      sbq.push_back(mk_exp(d1, 2, 1'b0, 1'b0));
      drive_beat(hdr, 1'b0);
      drive_beat(d1, 1'b0);
      s_TDATA = 32'hDEAD_0001;
      rst     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_s_tready", 32'(s_TREADY), 32'd0);
      chk("mrst_m_tvalid", 32'(m_TVALID), 32'd0);
      chk("mrst_grant", 32'(grant_sel), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_err", 32'(err_underflow), 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      s_TVALID = 1'b0;
      send_pkt(2, 0, 32'($urandom));

      for (int n = 0; n < 20 && sbq.size() > 0; n++) @(posedge clk);
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
